ecg_uart_framer: RTL and testbench

//  Downstream of the ADS1293 sequencer. Collects the register bytes it reads back
//  (CH1/CH2 ECG U/M/L, 6 bytes per sample) into a capture buffer.
//  It then emits each completed sample to the UART transmitter as a framed packet:

---
 rtl/ecg_uart_framer.sv | 186 ++++++++++++++++++
 tb/tb_ecg_uart_framer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecg_uart_framer.sv
// ecg_uart_framer: collects ADS1293 readback bytes into a capture buffer and
// sends each complete sample to the UART as a packet: HEADER, data bytes in
// arrival order, then the 8-bit sum of the data bytes.
// Capture and send use separate buffers, so the SPI read loop never waits.
// A sample that completes while a packet is still in flight is dropped and counted.
module ecg_uart_framer #(
  parameter int         N_BYTES = 6,
  parameter logic [7:0] HEADER  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_sof,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       frame_sent,
  output logic       busy,
  output logic [7:0] drop_count
);

  localparam int            IW   = $clog2(N_BYTES);
  localparam logic [IW-1:0] LAST = IW'(N_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [7:0]    cap_buf [N_BYTES];
  logic [7:0]    snd_buf [N_BYTES];

  logic [IW-1:0] cap_idx;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] snd_idx;
  logic [IW-1:0] snd_idx_inc;
  logic [IW-1:0] snd_idx_nxt;

  logic [7:0]    csum;
  logic [7:0]    csum_nxt;
  logic [7:0]    csum_add;

  logic [7:0]    tx_data_nxt;
  logic          tx_valid_nxt;
  logic          frame_sent_nxt;

  // start: snd_buf was loaded on the last edge and the FSM leaves IDLE on
  // this edge. The send path counts as occupied during that cycle so a very
  // short frame (N_BYTES=2) cannot silently overwrite a loaded snd_buf.
  logic          start;
  logic          frame_done;
  logic          send_free;
  logic          accept;

  // A start-of-frame byte, or any byte while cap_idx is 0, lands in slot 0.
  assign wr_idx      = byte_sof ? '0 : cap_idx;
  assign frame_done  = byte_valid && (wr_idx == LAST);
  assign send_free   = (state == S_IDLE) && !start;
  assign accept      = frame_done && send_free;

  assign snd_idx_inc = snd_idx + IW'(1);
  assign csum_add    = csum + tx_data;

  assign busy        = (state != S_IDLE);

  // Capture side: store each valid byte and advance or wrap the write index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_idx <= '0;
    end else if (byte_valid) begin
      cap_buf[wr_idx] <= byte_in;
      cap_idx         <= frame_done ? '0 : wr_idx + IW'(1);
    end
  end

  // Snapshot a completed frame into the send buffer, including the byte arriving now.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < N_BYTES - 1; i++) begin
        snd_buf[i] <= cap_buf[i];
      end
      snd_buf[N_BYTES-1] <= byte_in;
    end
  end

  // Launch request for the send FSM and the saturating count of dropped frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      start      <= 1'b0;
      drop_count <= 8'h00;
    end else begin
      start <= accept;
      if (frame_done && !send_free && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  // Send FSM state plus the registered UART-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      snd_idx    <= '0;
      csum       <= 8'h00;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      frame_sent <= 1'b0;
    end else begin
      state      <= state_nxt;
      snd_idx    <= snd_idx_nxt;
      csum       <= csum_nxt;
      tx_data    <= tx_data_nxt;
      tx_valid   <= tx_valid_nxt;
      frame_sent <= frame_sent_nxt;
    end
  end

  // Next-state logic; tx_data is precomputed for the following state so the
  // stream runs at one byte per cycle when tx_ready stays high.
  always_comb begin
    state_nxt      = state;
    snd_idx_nxt    = snd_idx;
    csum_nxt       = csum;
    tx_data_nxt    = tx_data;
    tx_valid_nxt   = tx_valid;
    frame_sent_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        tx_valid_nxt = 1'b0;
        tx_data_nxt  = 8'h00;
        if (accept) begin
          csum_nxt = 8'h00;
        end
        if (start) begin
          state_nxt    = S_HDR;
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = HEADER;
        end
      end

      S_HDR: begin
        if (tx_ready) begin
          state_nxt   = S_DATA;
          snd_idx_nxt = '0;
          tx_data_nxt = snd_buf[0];
        end
      end

      S_DATA: begin
        if (tx_ready) begin
          csum_nxt = csum_add;
          if (snd_idx == LAST) begin
            state_nxt   = S_CSUM;
            tx_data_nxt = csum_add;
          end else begin
            snd_idx_nxt = snd_idx_inc;
            tx_data_nxt = snd_buf[snd_idx_inc];
          end
        end
      end

      S_CSUM: begin
        if (tx_ready) begin
          state_nxt      = S_IDLE;
          tx_valid_nxt   = 1'b0;
          tx_data_nxt    = 8'h00;
          frame_sent_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt    = S_IDLE;
        tx_valid_nxt = 1'b0;
        tx_data_nxt  = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_ecg_uart_framer.sv
// tb_ecg_uart_framer: directed tests for ecg_uart_framer. The stimulus pushes
// expected packet bytes into a queue; a monitor pops and compares one entry on
// every tx handshake.
module tb_ecg_uart_framer;

  logic       clk;
  logic       rst;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_sof;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       frame_sent;
  logic       busy;
  logic [7:0] drop_count;

  logic [7:0] exp_q[$];
  int         checks;
  int         passes;
  int         sent_count;
  int         exp_sent;
  bit         mon_en;

  ecg_uart_framer #(
    .N_BYTES (6),
    .HEADER  (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_sof   (byte_sof),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .frame_sent (frame_sent),
    .busy       (busy),
    .drop_count (drop_count)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One byte on the capture interface, held for one clock edge.
  task automatic applyStimulus(input logic [7:0] b, input logic sof);
    @(posedge clk);
    #1;
    byte_in    = b;
    byte_valid = 1'b1;
    byte_sof   = sof;
  endtask

  task automatic stopBytes();
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_sof   = 1'b0;
    byte_in    = 8'h00;
  endtask

  // Six bytes, first one flagged as start of frame; f[47:40] is byte 0.
  task automatic sendFrame(input logic [47:0] f);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(f[47-8*i -: 8], (i == 0));
    end
    stopBytes();
  endtask

  task automatic expectFrame(input logic [47:0] f, input logic [7:0] sum);
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(f[47-8*i -: 8]);
    end
    exp_q.push_back(sum);
    exp_sent++;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_sof   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || tx_valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_done", 32'(n < budget), 1);
    @(posedge clk);
    #1;
    checkOutput("frame_sent_count", sent_count, exp_sent);
  endtask

  task automatic waitTxByte(input string name, input logic [7:0] b, input int budget);
    int n;
    n = 0;
    while (!(tx_valid && tx_data == b) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, 32'(n < budget), 1);
  endtask

  // Monitor: every accepted tx byte is compared against the next expected byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_sent) sent_count++;
      if (mon_en && tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_tx: got %0h, expected no byte at %0t", tx_data, $time);
        end else begin
          checkOutput("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Directed test sequence.
  initial begin
    int len;
    checks     = 0;
    passes     = 0;
    sent_count = 0;
    exp_sent   = 0;
    mon_en     = 1'b1;
    rst        = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    byte_sof   = 1'b0;
    tx_ready   = 1'b1;

    // Test 1: basic packet, reset values, latency and packet length.
    doReset();
    checkOutput("rst_tx_valid", 32'(tx_valid), 0);
    checkOutput("rst_tx_data", 32'(tx_data), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_drop", 32'(drop_count), 0);
    checkOutput("rst_frame_sent", 32'(frame_sent), 0);
    expectFrame(48'h010203040506, 8'h15);
    sendFrame(48'h010203040506);
    checkOutput("lat_pending_valid", 32'(tx_valid), 0);
    @(posedge clk);
    #1;
    checkOutput("lat_hdr_valid", 32'(tx_valid), 1);
    checkOutput("lat_hdr_data", 32'(tx_data), 'hA5);
    checkOutput("lat_busy", 32'(busy), 1);
    len = 0;
    while (tx_valid && len < 50) begin
      len++;
      @(posedge clk);
      #1;
    end
    checkOutput("packet_len", len, 8);
    waitDrain(50);
    checkOutput("t1_drop", 32'(drop_count), 0);

    // Test 2: backpressure while tx_data = 03.
    doReset();
    expectFrame(48'h010203040506, 8'h15);
    sendFrame(48'h010203040506);
    waitTxByte("find_03", 8'h03, 20);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_data", 32'(tx_data), 'h03);
      checkOutput("hold_valid", 32'(tx_valid), 1);
    end
    tx_ready = 1'b1;
    waitDrain(50);

    // Test 3: second frame completes while the first is stalled -> dropped.
    doReset();
    tx_ready = 1'b0;
    expectFrame(48'h010203040506, 8'h15);
    sendFrame(48'h010203040506);
    sendFrame(48'h101112131415);
    checkOutput("t3_drop", 32'(drop_count), 1);
    checkOutput("t3_busy", 32'(busy), 1);
    checkOutput("t3_hdr_held", 32'(tx_data), 'hA5);
    tx_ready = 1'b1;
    waitDrain(50);
    checkOutput("t3_drop_after", 32'(drop_count), 1);

    // Test 4: partial frame discarded by a later start-of-frame byte.
    doReset();
    tx_ready = 1'b1;
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hBB, 1'b0);
    applyStimulus(8'hCC, 1'b0);
    expectFrame(48'h010203040506, 8'h15);
    sendFrame(48'h010203040506);
    waitDrain(50);
    checkOutput("t4_drop", 32'(drop_count), 0);

    // Test 5: checksum wrap, then drop counter saturation.
    doReset();
    tx_ready = 1'b1;
    expectFrame(48'hFFFFFFFFFFFF, 8'hFA);
    sendFrame(48'hFFFFFFFFFFFF);
    waitDrain(50);
    tx_ready = 1'b0;
    expectFrame(48'h010203040506, 8'h15);
    sendFrame(48'h010203040506);
    for (int k = 0; k < 300; k++) begin
      sendFrame(48'h070707070707);
      if (k == 253) checkOutput("drop_254", 32'(drop_count), 'hFE);
      if (k == 254) checkOutput("drop_255", 32'(drop_count), 'hFF);
    end
    checkOutput("drop_sat", 32'(drop_count), 'hFF);
    checkOutput("t5_busy", 32'(busy), 1);
    tx_ready = 1'b1;
    waitDrain(50);

    // Test 6: reset while in DATA abandons the packet.
    doReset();
    mon_en   = 1'b0;
    tx_ready = 1'b1;
    sendFrame(48'h010203040506);
    waitTxByte("find_01", 8'h01, 20);
    tx_ready = 1'b0;
    checkOutput("t6_busy_data", 32'(busy), 1);
    sendFrame(48'h202122232425);
    checkOutput("t6_drop_pre", 32'(drop_count), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("t6_rst_valid", 32'(tx_valid), 0);
    checkOutput("t6_rst_busy", 32'(busy), 0);
    checkOutput("t6_rst_drop", 32'(drop_count), 0);
    checkOutput("t6_rst_data", 32'(tx_data), 0);
    tx_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checkOutput("t6_abandoned", 32'(tx_valid), 0);
    checkOutput("t6_no_pulse", sent_count, exp_sent);
    mon_en = 1'b1;
    expectFrame(48'h010203040506, 8'h15);
    sendFrame(48'h010203040506);
    waitDrain(50);

    checkOutput("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
